// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared defaults and entry layout for the softmax result collector
package softmax_pkg;

  localparam int DEF_N       = 16;
  localparam int DEF_VEC_LEN = 4;
  localparam int DEF_DEPTH   = 8;
  localparam int IDX_W       = $clog2(DEF_VEC_LEN);
  localparam int SUM_W       = DEF_N + IDX_W;

  typedef struct packed {
    logic [DEF_N-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/softmax_result_collector_if.sv
// rtl/softmax_result_collector_if.sv - downstream sample stream of the result collector
interface softmax_result_collector_if #(
  parameter int N     = 16,
  parameter int IDX_W = 2
) ();

  logic             m_valid;
  logic             m_ready;
  logic [N-1:0]     m_data;
  logic [IDX_W-1:0] m_index;
  logic             m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);

endinterface

// File: rtl/softmax_sync_fifo.sv
// rtl/softmax_sync_fifo.sv - single-clock show-ahead FIFO with wrap-bit pointers
module softmax_sync_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/softmax_result_collector.sv
// rtl/softmax_result_collector.sv - captures CORDIC softmax outputs, tags, buffers and sums them
module softmax_result_collector
  import softmax_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int VEC_LEN = DEF_VEC_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [N-1:0]                  z_in,
  input  logic                          capture_div,
  softmax_result_collector_if.master    m,
  output logic [N+$clog2(VEC_LEN)-1:0]  sum_out,
  output logic                          sum_valid,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int IW = $clog2(VEC_LEN);
  localparam int SW = N + IW;
  localparam int EW = N + IW + 1;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } slot_t;

  logic [IW-1:0] elem_cnt;
  logic [SW-1:0] acc;
  logic [SW-1:0] acc_next;
  slot_t         wr_slot;
  slot_t         head;
  slot_t         hold;
  slot_t         out_slot;
  logic          is_last;
  logic          full;
  logic          empty;
  logic          pop;

  assign is_last  = (elem_cnt == IW'(VEC_LEN - 1));
  assign acc_next = acc + SW'(z_in);
  assign wr_slot  = '{data: z_in, idx: elem_cnt, last: is_last};
  assign pop      = !empty && m.m_ready && !clear;

  softmax_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (capture_div),
    .push_data (wr_slot),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // When empty the stream shows the last beat that left, not stale RAM contents.
  always_comb begin
    out_slot  = empty ? hold : head;
    m.m_valid = !empty;
    m.m_data  = out_slot.data;
    m.m_index = out_slot.idx;
    m.m_last  = out_slot.last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt  <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      hold      <= '0;
    end else if (clear) begin
      elem_cnt  <= '0;
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      hold      <= '0;
    end else begin
      sum_valid <= 1'b0;
      if (pop) hold <= head;
      // Dropped strobes still advance framing and the sum so vectors stay aligned.
      if (capture_div) begin
        if (full && !pop) overflow <= 1'b1;
        if (is_last) begin
          elem_cnt  <= '0;
          sum_out   <= acc_next;
          sum_valid <= 1'b1;
          acc       <= '0;
        end else begin
          elem_cnt  <= elem_cnt + 1'b1;
          acc       <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_result_collector.sv
// tb/tb_softmax_result_collector.sv - directed self-checking bench for the softmax result collector
module tb_softmax_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] z_in;
  logic        capture_div;
  logic [17:0] sum_out;
  logic        sum_valid;
  logic        overflow;
  logic [3:0]  level;

  int checks = 0;
  int errors = 0;

  logic [15:0] bd[$];
  logic [15:0] bi[$];
  logic [15:0] bl[$];
  int          sum_cnt = 0;
  logic [17:0] last_sum = '0;
  logic        stall_en = 1'b0;
  logic        stall_pending = 1'b0;
  logic [15:0] stall_data = '0;

  softmax_result_collector_if #(.N(16), .IDX_W(2)) m_if ();

  softmax_result_collector #(.N(16), .DEPTH(8), .VEC_LEN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .z_in        (z_in),
    .capture_div (capture_div),
    .m           (m_if.master),
    .sum_out     (sum_out),
    .sum_valid   (sum_valid),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] at(input logic [15:0] q[$], input int k);
    return (k < q.size()) ? q[k] : 16'hdead;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] z);
    z_in        = z;
    capture_div = 1'b1;
    tick(1);
    capture_div = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  always @(posedge clk) begin
    if (m_if.m_valid && m_if.m_ready) begin
      bd.push_back(m_if.m_data);
      bi.push_back(16'(m_if.m_index));
      bl.push_back(16'(m_if.m_last));
    end
    if (sum_valid) begin
      sum_cnt  <= sum_cnt + 1;
      last_sum <= sum_out;
    end
    if (stall_en && stall_pending && m_if.m_valid)
      chk("stall_hold", 32'(m_if.m_data), 32'(stall_data));
    stall_pending <= m_if.m_valid && !m_if.m_ready;
    stall_data    <= m_if.m_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] t1_z [4];
    int b;
    int s;
    t1_z = '{16'h4000, 16'h3000, 16'h0800, 16'h0800};

    reset = 1'b0; clear = 1'b0; capture_div = 1'b0; z_in = '0; m_if.m_ready = 1'b0;
    tick(2);
    chk("rst_valid",    32'(m_if.m_valid), 32'd0);
    chk("rst_data",     32'(m_if.m_data),  32'd0);
    chk("rst_index",    32'(m_if.m_index), 32'd0);
    chk("rst_last",     32'(m_if.m_last),  32'd0);
    chk("rst_sum",      32'(sum_out),      32'd0);
    chk("rst_sumvalid", 32'(sum_valid),    32'd0);
    chk("rst_overflow", 32'(overflow),     32'd0);
    chk("rst_level",    32'(level),        32'd0);
    reset = 1'b1;
    tick(1);

    // basic vector
    m_if.m_ready = 1'b1;
    b = bd.size(); s = sum_cnt;
    for (int i = 0; i < 4; i++) strobe(t1_z[i]);
    tick(3);
    chk("t1_beats", 32'(bd.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), 32'(at(bd, b + i)), 32'(t1_z[i]));
      chk($sformatf("t1_idx%0d", i),  32'(at(bi, b + i)), 32'(i));
      chk($sformatf("t1_last%0d", i), 32'(at(bl, b + i)), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t1_sumcnt", 32'(sum_cnt - s), 32'd1);
    chk("t1_sum",    32'(last_sum),    32'h08000);

    // overflow and framing
    m_if.m_ready = 1'b0;
    b = bd.size(); s = sum_cnt;
    for (int i = 0; i < 8; i++) strobe(16'h0100 + 16'(i));
    chk("t2_level_full", 32'(level),    32'd8);
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    strobe(16'h0108);
    chk("t2_level_drop", 32'(level),    32'd8);
    chk("t2_ovf_after",  32'(overflow), 32'd1);
    chk("t2_sumcnt",     32'(sum_cnt - s), 32'd2);
    chk("t2_sum",        32'(last_sum),    32'h00416);
    m_if.m_ready = 1'b1;
    tick(10);
    chk("t2_beats", 32'(bd.size() - b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_data%0d", i), 32'(at(bd, b + i)), 32'h100 + 32'(i));
      chk($sformatf("t2_idx%0d", i),  32'(at(bi, b + i)), 32'(i % 4));
    end
    strobe(16'h01AA);
    tick(2);
    chk("t2_next_data", 32'(at(bd, b + 8)), 32'h01AA);
    chk("t2_next_idx",  32'(at(bi, b + 8)), 32'd1);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);
    pulse_clear();
    chk("t2_ovf_clear",   32'(overflow), 32'd0);
    chk("t2_level_clear", 32'(level),    32'd0);

    // full with simultaneous push and pop
    m_if.m_ready = 1'b0;
    b = bd.size();
    for (int i = 0; i < 8; i++) strobe(16'h0200 + 16'(i));
    chk("t3_level_full", 32'(level), 32'd8);
    m_if.m_ready = 1'b1;
    strobe(16'h0208);
    m_if.m_ready = 1'b0;
    chk("t3_level_same", 32'(level),    32'd8);
    chk("t3_no_ovf",     32'(overflow), 32'd0);
    m_if.m_ready = 1'b1;
    tick(10);
    chk("t3_beats", 32'(bd.size() - b), 32'd9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("t3_data%0d", i), 32'(at(bd, b + i)), 32'h200 + 32'(i));
    pulse_clear();

    // ready toggling
    b = bd.size(); s = sum_cnt;
    stall_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      capture_div  = (i < 4);
      z_in         = 16'h3000 + 16'(i);
      m_if.m_ready = (i % 2 == 0);
      tick(1);
    end
    capture_div  = 1'b0;
    m_if.m_ready = 1'b1;
    tick(2);
    stall_en = 1'b0;
    chk("t4_beats", 32'(bd.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_data%0d", i), 32'(at(bd, b + i)), 32'h3000 + 32'(i));
      chk($sformatf("t4_idx%0d", i),  32'(at(bi, b + i)), 32'(i));
    end
    chk("t4_sum", 32'(last_sum), 32'h0C006);

    // clear mid-vector
    m_if.m_ready = 1'b0;
    strobe(16'h0010);
    strobe(16'h0020);
    chk("t5_level_pre", 32'(level), 32'd2);
    pulse_clear();
    chk("t5_level", 32'(level),         32'd0);
    chk("t5_valid", 32'(m_if.m_valid),  32'd0);
    chk("t5_data",  32'(m_if.m_data),   32'd0);
    b = bd.size(); s = sum_cnt;
    m_if.m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) strobe(16'(i));
    tick(3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_data%0d", i), 32'(at(bd, b + i)), 32'(i + 1));
      chk($sformatf("t5_idx%0d", i),  32'(at(bi, b + i)), 32'(i));
    end
    chk("t5_sumcnt", 32'(sum_cnt - s), 32'd1);
    chk("t5_sum",    32'(last_sum),    32'h0000A);

    // async reset mid-drain
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) strobe(16'h0500 + 16'(i));
    m_if.m_ready = 1'b1;
    tick(2);
    m_if.m_ready = 1'b0;
    chk("t6_level_pre", 32'(level), 32'd5);
    reset = 1'b0;
    #1;
    chk("t6_valid", 32'(m_if.m_valid), 32'd0);
    chk("t6_level", 32'(level),        32'd0);
    chk("t6_data",  32'(m_if.m_data),  32'd0);
    chk("t6_sum",   32'(sum_out),      32'd0);
    #2;
    reset = 1'b1;
    tick(1);
    b = bd.size();
    m_if.m_ready = 1'b1;
    strobe(16'h0077);
    tick(2);
    chk("t6_first_data", 32'(at(bd, b)), 32'h0077);
    chk("t6_first_idx",  32'(at(bi, b)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
